// File: rtl/dca_matrix_load2mreg_multi_if.sv
// dca_matrix_load2mreg_multi_if: control, row-load, matrix-write and release signals of the multi-channel loader
interface dca_matrix_load2mreg_multi_if #(
    parameter int NUM_CHANNEL   = 3,
    parameter int BW_TENSOR_ROW = 256
);
    logic                                   clear;
    logic                                   enable;
    logic                                   busy;
    logic [NUM_CHANNEL-1:0]                 load_tensor_row_wvalid;
    logic [NUM_CHANNEL-1:0]                 load_tensor_row_wlast;
    logic [NUM_CHANNEL-1:0]                 load_tensor_row_wready;
    logic [NUM_CHANNEL*BW_TENSOR_ROW-1:0]   load_tensor_row_wdata;
    logic [NUM_CHANNEL-1:0]                 mreg_move_wenable;
    logic [NUM_CHANNEL*BW_TENSOR_ROW-1:0]   mreg_move_wdata_list1d;
    logic [NUM_CHANNEL-1:0]                 loadreg_rready;
    logic [NUM_CHANNEL-1:0]                 loadreg_rrequest;
    logic                                   loadreg_all_rready;
    logic                                   loadreg_all_rrequest;
    logic [NUM_CHANNEL-1:0]                 overflow_error;

    modport master (
        output clear, enable, load_tensor_row_wvalid, load_tensor_row_wlast, load_tensor_row_wdata,
               loadreg_rrequest, loadreg_all_rrequest,
        input  busy, load_tensor_row_wready, mreg_move_wenable, mreg_move_wdata_list1d,
               loadreg_rready, loadreg_all_rready, overflow_error
    );

    modport slave (
        input  clear, enable, load_tensor_row_wvalid, load_tensor_row_wlast, load_tensor_row_wdata,
               loadreg_rrequest, loadreg_all_rrequest,
        output busy, load_tensor_row_wready, mreg_move_wenable, mreg_move_wdata_list1d,
               loadreg_rready, loadreg_all_rready, overflow_error
    );
endinterface

// File: rtl/dca_matrix_load2mreg_multi.sv
// dca_matrix_load2mreg_multi: per-channel tensor-row loader that fills, zero-pads and hands off matrix registers
module dca_matrix_load2mreg_multi #(
    parameter int MATRIX_SIZE   = 8,
    parameter int BW_TENSOR_ROW = 256,
    parameter int NUM_CHANNEL   = 3,
    parameter bit ZERO_PAD      = 1
) (
    input logic                        clk,
    input logic                        rstnn,
    dca_matrix_load2mreg_multi_if.slave bus
);
    localparam int            CW   = $clog2(MATRIX_SIZE + 1);
    localparam logic [CW-1:0] LAST = CW'(MATRIX_SIZE);

    typedef enum logic [1:0] {FILL, PAD, FULL} state_e;

    state_e                               state_q [NUM_CHANNEL];
    state_e                               state_d [NUM_CHANNEL];
    logic [CW-1:0]                        cnt_q   [NUM_CHANNEL];
    logic [CW-1:0]                        cnt_d   [NUM_CHANNEL];
    logic [CW-1:0]                        cnt_inc [NUM_CHANNEL];
    logic [NUM_CHANNEL-1:0]               ovf_q, ovf_d;
    logic [NUM_CHANNEL-1:0]               wready, acc, wenable, rready, busy_ch;
    logic [NUM_CHANNEL*BW_TENSOR_ROW-1:0] wdata;
    logic                                 all_rready, go;

    assign go = bus.enable & ~bus.clear & rstnn;

    // handshake outputs and next-state of every channel; clear beats enable, enable beats everything else
    always_comb begin
        for (int k = 0; k < NUM_CHANNEL; k++)
            rready[k] = (state_q[k] == FULL) && !bus.clear;
        all_rready = &rready;
        for (int k = 0; k < NUM_CHANNEL; k++) begin
            wready[k]  = go && (state_q[k] == FILL);
            acc[k]     = wready[k] & bus.load_tensor_row_wvalid[k];
            wenable[k] = acc[k] | (go && (state_q[k] == PAD));
            wdata[k*BW_TENSOR_ROW +: BW_TENSOR_ROW] = acc[k] ? bus.load_tensor_row_wdata[k*BW_TENSOR_ROW +: BW_TENSOR_ROW] : '0;
            busy_ch[k] = !bus.clear && ((state_q[k] == PAD) || ((state_q[k] == FILL) && (cnt_q[k] != '0)));
            cnt_inc[k] = cnt_q[k] + CW'(1);
            state_d[k] = state_q[k];
            cnt_d[k]   = cnt_q[k];
            ovf_d[k]   = ovf_q[k];
            if (bus.clear) begin
                state_d[k] = FILL;
                cnt_d[k]   = '0;
                ovf_d[k]   = 1'b0;
            end else if (bus.enable) begin
                if (acc[k]) begin
                    cnt_d[k] = cnt_inc[k];
                    if (cnt_inc[k] == LAST) begin
                        state_d[k] = FULL;
                        ovf_d[k]   = ovf_q[k] | ~bus.load_tensor_row_wlast[k];
                    end else if (bus.load_tensor_row_wlast[k]) begin
                        state_d[k] = ZERO_PAD ? PAD : FULL;
                    end
                end else if (state_q[k] == PAD) begin
                    cnt_d[k] = cnt_inc[k];
                    if (cnt_inc[k] == LAST)
                        state_d[k] = FULL;
                end else if ((state_q[k] == FULL) && (bus.loadreg_rrequest[k] || (bus.loadreg_all_rrequest && all_rready))) begin
                    state_d[k] = FILL;
                    cnt_d[k]   = '0;
                end
            end
        end
    end

    // channel state registers, reset discards any partial matrix
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            for (int k = 0; k < NUM_CHANNEL; k++) begin
                state_q[k] <= FILL;
                cnt_q[k]   <= '0;
            end
            ovf_q <= '0;
        end else begin
            for (int k = 0; k < NUM_CHANNEL; k++) begin
                state_q[k] <= state_d[k];
                cnt_q[k]   <= cnt_d[k];
            end
            ovf_q <= ovf_d;
        end
    end

    assign bus.load_tensor_row_wready = wready;
    assign bus.mreg_move_wenable      = wenable;
    assign bus.mreg_move_wdata_list1d = wdata;
    assign bus.loadreg_rready         = rready;
    assign bus.loadreg_all_rready     = all_rready;
    assign bus.overflow_error         = ovf_q;
    assign bus.busy                   = |busy_ch;
endmodule

// File: tb/tb_dca_matrix_load2mreg_multi.sv
// tb_dca_matrix_load2mreg_multi: directed scoreboard bench for the multi-channel matrix loader
module tb_dca_matrix_load2mreg_multi;
    localparam int MS = 4;
    localparam int NC = 2;
    localparam int BW = 32;

    logic clk = 1'b0;
    logic rstnn;
    int   vectors = 0;
    int   errors  = 0;
    logic [BW-1:0] q0 [$];
    logic [BW-1:0] q1 [$];

    always #5 clk = ~clk;

    dca_matrix_load2mreg_multi_if #(.NUM_CHANNEL(NC), .BW_TENSOR_ROW(BW)) bus ();

    dca_matrix_load2mreg_multi #(
        .MATRIX_SIZE(MS), .BW_TENSOR_ROW(BW), .NUM_CHANNEL(NC), .ZERO_PAD(1)
    ) dut (
        .clk(clk),
        .rstnn(rstnn),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int ch, input logic [BW-1:0] d, input logic last);
        bus.load_tensor_row_wvalid[ch] = 1'b1;
        bus.load_tensor_row_wlast[ch]  = last;
        bus.load_tensor_row_wdata[ch*BW +: BW] = d;
        if (ch == 0) q0.push_back(d);
        else q1.push_back(d);
        @(negedge clk);
        chk("wready_on_send", 64'(bus.load_tensor_row_wready[ch]), 64'd1);
        tick();
        bus.load_tensor_row_wvalid[ch] = 1'b0;
        bus.load_tensor_row_wlast[ch]  = 1'b0;
    endtask

    // every row written to the matrix register must be the next one the scoreboard expects
    always @(negedge clk) begin
        logic [BW-1:0] d;
        logic [BW-1:0] e;
        for (int k = 0; k < NC; k++) begin
            d = bus.mreg_move_wdata_list1d[k*BW +: BW];
            if (bus.mreg_move_wenable[k]) begin
                if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0))
                    chk("wenable_unexpected", 64'(bus.mreg_move_wenable[k]), 64'd0);
                else begin
                    e = (k == 0) ? q0.pop_front() : q1.pop_front();
                    chk("wdata", 64'(d), 64'(e));
                end
            end else
                chk("idle_wdata_zero", 64'(d), 64'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstnn = 1'b0;
        bus.clear = 1'b0;
        bus.enable = 1'b1;
        bus.load_tensor_row_wvalid = '0;
        bus.load_tensor_row_wlast = '0;
        bus.load_tensor_row_wdata = '0;
        bus.loadreg_rrequest = '0;
        bus.loadreg_all_rrequest = 1'b0;
        @(negedge clk);
        chk("rst_wready", 64'(bus.load_tensor_row_wready), 64'd0);
        chk("rst_rready", 64'(bus.loadreg_rready), 64'd0);
        chk("rst_all_rready", 64'(bus.loadreg_all_rready), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_ovf", 64'(bus.overflow_error), 64'd0);
        #2 rstnn = 1'b1;
        tick();
        chk("post_rst_wready", 64'(bus.load_tensor_row_wready), 64'd3);

        // full load on ch0
        send(0, 32'hA0A0_0001, 1'b0);
        chk("full_busy", 64'(bus.busy), 64'd1);
        send(0, 32'hB0B0_0002, 1'b0);
        send(0, 32'hC0C0_0003, 1'b0);
        chk("full_rready_early", 64'(bus.loadreg_rready), 64'd0);
        send(0, 32'hD0D0_0004, 1'b1);
        chk("full_rready", 64'(bus.loadreg_rready), 64'd1);
        chk("full_ovf", 64'(bus.overflow_error), 64'd0);
        chk("full_busy_idle", 64'(bus.busy), 64'd0);

        // group release with only ch0 full is ignored
        bus.loadreg_all_rrequest = 1'b1;
        tick();
        bus.loadreg_all_rrequest = 1'b0;
        chk("group_partial_ignored", 64'(bus.loadreg_rready), 64'd1);

        // short load on ch1 pads two zero rows
        send(1, 32'h1111_0001, 1'b0);
        send(1, 32'h2222_0002, 1'b1);
        q1.push_back('0);
        q1.push_back('0);
        chk("pad_busy1", 64'(bus.busy), 64'd1);
        chk("pad_wready", 64'(bus.load_tensor_row_wready[1]), 64'd0);
        tick();
        chk("pad_busy2", 64'(bus.busy), 64'd1);
        chk("pad_rready_early", 64'(bus.loadreg_rready[1]), 64'd0);
        tick();
        chk("pad_rready", 64'(bus.loadreg_rready), 64'd3);
        chk("pad_done_busy", 64'(bus.busy), 64'd0);
        chk("all_rready", 64'(bus.loadreg_all_rready), 64'd1);

        // group release with both full
        bus.loadreg_all_rrequest = 1'b1;
        tick();
        bus.loadreg_all_rrequest = 1'b0;
        chk("group_wready", 64'(bus.load_tensor_row_wready), 64'd3);
        chk("group_rready", 64'(bus.loadreg_rready), 64'd0);

        // overflow on ch0
        send(0, 32'h0F00_0001, 1'b0);
        send(0, 32'h0F00_0002, 1'b0);
        send(0, 32'h0F00_0003, 1'b0);
        send(0, 32'h0F00_0004, 1'b0);
        chk("ovf_rready", 64'(bus.loadreg_rready), 64'd1);
        chk("ovf_flag", 64'(bus.overflow_error), 64'd1);
        bus.loadreg_rrequest[0] = 1'b1;
        tick();
        bus.loadreg_rrequest[0] = 1'b0;
        chk("ovf_released", 64'(bus.loadreg_rready), 64'd0);
        chk("ovf_sticky", 64'(bus.overflow_error), 64'd1);
        bus.clear = 1'b1;
        @(negedge clk);
        chk("clear_wready", 64'(bus.load_tensor_row_wready), 64'd0);
        tick();
        bus.clear = 1'b0;
        chk("ovf_cleared", 64'(bus.overflow_error), 64'd0);

        // clear coincident with an accepted beat
        send(0, 32'h5555_0001, 1'b0);
        chk("pre_clear_busy", 64'(bus.busy), 64'd1);
        bus.clear = 1'b1;
        bus.load_tensor_row_wvalid[0] = 1'b1;
        bus.load_tensor_row_wdata[0 +: BW] = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("clear_wenable", 64'(bus.mreg_move_wenable), 64'd0);
        tick();
        bus.clear = 1'b0;
        bus.load_tensor_row_wvalid[0] = 1'b0;
        chk("clear_busy", 64'(bus.busy), 64'd0);
        send(0, 32'h6666_0001, 1'b0);
        send(0, 32'h6666_0002, 1'b0);
        send(0, 32'h6666_0003, 1'b0);
        chk("clear_count_zero", 64'(bus.loadreg_rready), 64'd0);
        send(0, 32'h6666_0004, 1'b1);
        chk("clear_reload_full", 64'(bus.loadreg_rready), 64'd1);
        bus.loadreg_rrequest[0] = 1'b1;
        tick();
        bus.loadreg_rrequest[0] = 1'b0;

        // freeze during padding on ch1
        send(1, 32'h7777_0001, 1'b1);
        q1.push_back('0);
        q1.push_back('0);
        q1.push_back('0);
        tick();
        bus.enable = 1'b0;
        @(negedge clk);
        chk("freeze_wenable", 64'(bus.mreg_move_wenable), 64'd0);
        chk("freeze_wready", 64'(bus.load_tensor_row_wready), 64'd0);
        chk("freeze_busy", 64'(bus.busy), 64'd1);
        tick();
        tick();
        bus.enable = 1'b1;
        tick();
        chk("freeze_rready_early", 64'(bus.loadreg_rready[1]), 64'd0);
        tick();
        chk("freeze_rready", 64'(bus.loadreg_rready[1]), 64'd1);
        chk("freeze_pads_done", 64'(q1.size()), 64'd0);
        bus.loadreg_rrequest[1] = 1'b1;
        tick();
        bus.loadreg_rrequest[1] = 1'b0;

        // reset mid-matrix
        send(0, 32'h8888_0001, 1'b0);
        send(0, 32'h8888_0002, 1'b0);
        send(0, 32'h8888_0003, 1'b0);
        bus.load_tensor_row_wvalid[0] = 1'b1;
        bus.load_tensor_row_wdata[0 +: BW] = 32'hBAD0_BAD0;
        #2 rstnn = 1'b0;
        #1;
        chk("mid_rst_wready", 64'(bus.load_tensor_row_wready), 64'd0);
        chk("mid_rst_wenable", 64'(bus.mreg_move_wenable), 64'd0);
        chk("mid_rst_busy", 64'(bus.busy), 64'd0);
        chk("mid_rst_rready", 64'(bus.loadreg_rready), 64'd0);
        @(posedge clk);
        #3;
        bus.load_tensor_row_wvalid[0] = 1'b0;
        rstnn = 1'b1;
        tick();
        send(0, 32'h9999_0001, 1'b0);
        send(0, 32'h9999_0002, 1'b0);
        send(0, 32'h9999_0003, 1'b0);
        chk("post_rst_partial", 64'(bus.loadreg_rready), 64'd0);
        send(0, 32'h9999_0004, 1'b1);
        chk("post_rst_full", 64'(bus.loadreg_rready), 64'd1);
        chk("post_rst_ovf", 64'(bus.overflow_error), 64'd0);

        tick();
        chk("q0_drained", 64'(q0.size()), 64'd0);
        chk("q1_drained", 64'(q1.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/dca_matrix_load2mreg_multi.md
DCA_MATRIX_LOAD2MREG_MULTI -- requirements
Module: dca_matrix_load2mreg_multi

Interface
REQ-001 SHALL have parameter MATRIX_SIZE, default 8: rows per matrix register; must be at least 2.
REQ-002 SHALL have parameter BW_TENSOR_ROW, default 256: width of one tensor row.
REQ-003 SHALL have parameter NUM_CHANNEL, default 3: number of independent load channels, range 1..8.
REQ-004 SHALL have parameter ZERO_PAD, default 1: when 1, short matrices are zero-padded; when 0, an early wlast completes the matrix immediately.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rstnn, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have ports clear and enable, input, 1 bit each: clear is a synchronous flush; enable is a global freeze when 0.
REQ-008 SHALL have port busy, output, 1 bit: some channel holds a partial matrix or is padding.
REQ-009 SHALL have ports load_tensor_row_wvalid, wlast and wready, each NUM_CHANNEL bits (wvalid and wlast inputs, wready output): per-channel row handshake.
REQ-010 SHALL have port load_tensor_row_wdata, input, NUM_CHANNEL*BW_TENSOR_ROW bits: channel k occupies slice k.
REQ-011 SHALL have ports mreg_move_wenable (NUM_CHANNEL bits) and mreg_move_wdata_list1d (NUM_CHANNEL*BW_TENSOR_ROW bits), outputs: per-channel row writes to the matrix register.
REQ-012 SHALL have ports loadreg_rready (output, NUM_CHANNEL bits) and loadreg_rrequest (input, NUM_CHANNEL bits): per-channel full/release handshake.
REQ-013 SHALL have ports loadreg_all_rready (output, 1 bit) and loadreg_all_rrequest (input, 1 bit): group full/release handshake.
REQ-014 SHALL have port overflow_error, output, NUM_CHANNEL bits: sticky flag set when a row count reaches MATRIX_SIZE without wlast.

Function
REQ-015 SHALL give each channel an independent FSM with states FILL, PAD and FULL, plus a row counter of clog2(MATRIX_SIZE+1) bits.
REQ-016 SHALL drive wready[k] = enable AND (state==FILL) AND NOT clear.
REQ-017 SHALL define an accepted beat as wvalid[k] AND wready[k]; on that beat, mreg_move_wenable[k]=1 and wdata slice k passes combinationally to mreg_move_wdata slice k (zero-cycle latency), and the counter increments.
REQ-018 SHALL, in FILL, move to FULL when an accepted beat makes count==MATRIX_SIZE; overflow_error[k] is set if wlast[k]=0 on that beat.
REQ-019 SHALL, in FILL, on an accepted beat with wlast=1 and count+1<MATRIX_SIZE, move to PAD if ZERO_PAD=1, else to FULL leaving remaining rows unwritten.
REQ-020 SHALL, in PAD with enable=1, assert wenable[k] with all-zero data each cycle, increment the count, and move to FULL when the count reaches MATRIX_SIZE; the padding row count equals MATRIX_SIZE minus rows received.
REQ-021 SHALL drive loadreg_rready[k] = (state==FULL) and loadreg_all_rready = AND of all loadreg_rready.
REQ-022 SHALL, in FULL, return to FILL with count 0 on loadreg_rrequest[k], or on loadreg_all_rrequest while loadreg_all_rready=1; a request in any other state, or all_rrequest while all_rready=0, is ignored.
REQ-023 SHALL, when enable=0, hold all state and counters, force wready=0 and wenable=0, and ignore rrequest.
REQ-024 SHALL, when clear=1, move every channel to FILL with count 0, clear overflow_error, and force outputs inactive that cycle; clear has priority over all other events including a simultaneous accept or release.
REQ-025 SHALL drive busy = OR over channels of (PAD, or FILL with count!=0).
REQ-026 SHALL give mreg_move_wdata slice k the value 0 whenever wenable[k]=0.

Reset
REQ-027 SHALL, while rstnn=0, asynchronously set every channel to FILL with count 0 and overflow_error 0; outputs are then wready=0 (while rstnn=0), wenable=0, rready=0, all_rready=0, busy=0.
REQ-028 SHALL, on a reset asserted mid-matrix, discard the partial matrix with no further wenable pulses.

Verification (MATRIX_SIZE=4, NUM_CHANNEL=2, ZERO_PAD=1)
REQ-029 SHALL cover a full load: ch0 sends 4 rows A,B,C,D with wlast on D -> 4 wenable pulses carrying A..D; rready[0]=1 from the next cycle; overflow_error=0.
REQ-030 SHALL cover a short load: ch1 sends 2 rows with wlast on the 2nd -> then 2 consecutive zero-data wenable cycles, then rready[1]=1; busy=1 during padding.
REQ-031 SHALL cover an overflow: ch0 sends 4 rows without wlast -> FULL entered and overflow_error[0]=1; the flag holds after release until clear.
REQ-032 SHALL cover the group release: both channels FULL, all_rrequest=1 for 1 cycle -> both channels in FILL and wready=11 the next cycle; all_rrequest with only ch0 FULL -> no change.
REQ-033 SHALL cover clear and freeze: clear coincident with an accepted beat -> no wenable and count 0; enable=0 during PAD -> padding stalls and resumes with the correct remaining count.
REQ-034 SHALL cover reset mid-matrix: rstnn low after 3 rows -> outputs at reset values immediately; a new 4-row load completes normally.
